fetch_unit: RTL and testbench

- Parametrised successor to the free-running PC/ROB-id fetch stage at the head of the cpu pipeline.
- Drives the instruction ROM address and holds one fetched instruction in an output register with a valid/ready handshake toward decode.
- Tags each instruction with a ROB id from a bounded in-order allocator, so fetch stalls when the ROB is full.
- Adds flush/redirect with allocator rollback, and retire-driven id release.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/robid_alloc.sv | 62 ++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Default widths and the packed fetch-output bundle for the cpu top.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int PC_W_DEF    = 6;
  localparam int INSTR_W_DEF = 16;
  localparam int ROBID_W_DEF = 4;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    pc;
    logic [ROBID_W_DEF-1:0] robid;
  } fetch_out_t;

endpackage

`default_nettype wire

// File: rtl/robid_alloc.sv
// ============================================================================
// Module : robid_alloc
// Brief  : In-order ROB id allocator with retire release and flush rollback.
// Rev    : 1.0
// ============================================================================
`default_nettype none

import fetch_pkg::*;

module robid_alloc #(
  parameter int ROBID_W = ROBID_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_alloc,
  input  logic               i_retire,
  input  logic               i_flush,
  input  logic [ROBID_W-1:0] i_flush_robid,
  output logic [ROBID_W-1:0] o_tail,
  output logic [ROBID_W:0]   o_count,
  output logic               o_full
);

  localparam logic [ROBID_W:0] c_depth = (ROBID_W+1)'(1) << ROBID_W;

  logic [ROBID_W-1:0] r_head;
  logic [ROBID_W-1:0] r_tail;
  logic [ROBID_W:0]   r_count;
  logic               w_ret_eff;
  logic [ROBID_W-1:0] w_head_nxt;

  // A retire against an empty ROB has nothing to release.
  assign w_ret_eff  = i_retire && (r_count != '0);
  assign w_head_nxt = r_head + ROBID_W'(w_ret_eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head <= w_head_nxt;
      if (i_flush) begin
        // Rollback is measured from the head after this cycle's retire.
        r_tail  <= i_flush_robid;
        r_count <= {1'b0, i_flush_robid - w_head_nxt};
      end else begin
        if (i_alloc) begin
          r_tail <= r_tail + 1'b1;
        end
        r_count <= r_count + (ROBID_W+1)'(i_alloc) - (ROBID_W+1)'(w_ret_eff);
      end
    end
  end

  assign o_tail  = r_tail;
  assign o_count = r_count;
  assign o_full  = (r_count == c_depth);

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Brief  : PC/ROB-id fetch stage with output handshake, flush and retire.
//          Optional perf counters enabled by defining FETCH_PERF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

import fetch_pkg::*;

module fetch_unit #(
  parameter int               PC_W     = PC_W_DEF,
  parameter int               INSTR_W  = INSTR_W_DEF,
  parameter int               ROBID_W  = ROBID_W_DEF,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [ROBID_W-1:0] out_robid,
  input  logic               retire_valid,
  input  logic               flush_valid,
  input  logic [PC_W-1:0]    flush_pc,
  input  logic [ROBID_W-1:0] flush_robid,
  output logic [ROBID_W:0]   rob_count,
  output logic               rob_full
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall_full
`endif
);

  logic [PC_W-1:0]    r_pc;
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_out_pc;
  logic [ROBID_W-1:0] r_robid;
  logic               w_fire;
  logic               w_full;
  logic [ROBID_W-1:0] w_tail;
  logic [ROBID_W:0]   w_count;

  // Count never exceeds DEPTH, so !full is the same as count < DEPTH.
  assign w_fire = !flush_valid && !w_full && (!r_valid || out_ready);

  robid_alloc #(
    .ROBID_W (ROBID_W)
  ) u_alloc (
    .clk           (clk),
    .rst           (rst),
    .i_alloc       (w_fire),
    .i_retire      (retire_valid),
    .i_flush       (flush_valid),
    .i_flush_robid (flush_robid),
    .o_tail        (w_tail),
    .o_count       (w_count),
    .o_full        (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_valid  <= 1'b0;
      r_instr  <= '0;
      r_out_pc <= '0;
      r_robid  <= '0;
    end else if (flush_valid) begin
      r_valid <= 1'b0;
      r_pc    <= flush_pc;
    end else if (w_fire) begin
      r_valid  <= 1'b1;
      r_instr  <= imem_data;
      r_out_pc <= r_pc;
      r_robid  <= w_tail;
      r_pc     <= r_pc + 1'b1;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched    <= '0;
      r_perf_stall_full <= '0;
    end else begin
      if (w_fire && (r_perf_fetched != '1)) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_full && !flush_valid && (r_perf_stall_full != '1)) begin
        r_perf_stall_full <= r_perf_stall_full + 32'd1;
      end
    end
  end

  assign perf_fetched    = r_perf_fetched;
  assign perf_stall_full = r_perf_stall_full;
`endif

  assign imem_addr = r_pc;
  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_pc    = r_out_pc;
  assign out_robid = r_robid;
  assign rob_count = w_count;
  assign rob_full  = w_full;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Scoreboard bench for fetch_unit against a queue-based ROB model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  imem_addr;
  logic [15:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [5:0]  out_pc;
  logic [3:0]  out_robid;
  logic        retire_valid;
  logic        flush_valid;
  logic [5:0]  flush_pc;
  logic [3:0]  flush_robid;
  logic [4:0]  rob_count;
  logic        rob_full;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_full;
`endif

  always #5 clk = ~clk;

  // ROM: word k holds 16'h1000 + k
  assign imem_data = 16'h1000 + {10'd0, imem_addr};

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_robid    (out_robid),
    .retire_valid (retire_valid),
    .flush_valid  (flush_valid),
    .flush_pc     (flush_pc),
    .flush_robid  (flush_robid),
    .rob_count    (rob_count),
    .rob_full     (rob_full)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_stall_full (perf_stall_full)
`endif
  );

  typedef struct {
    int instr;
    int pc;
    int rid;
  } exp_t;

  exp_t exp_q[$];
  int   rob_q[$];
  int   m_pc;
  int   m_head;
  int   m_tail;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ROB as a queue of live ids, output as a queue of pending words.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      rob_q.delete();
      m_pc   = 0;
      m_head = 0;
      m_tail = 0;
    end else begin
      bit fire;
      fire = !flush_valid && (rob_q.size() < 16) && (exp_q.size() == 0 || out_ready);
      if (retire_valid && rob_q.size() > 0) begin
        void'(rob_q.pop_front());
        m_head = (m_head + 1) % 16;
      end
      if (flush_valid) begin
        exp_q.delete();
        rob_q.delete();
        for (int id = m_head; id != int'(flush_robid); id = (id + 1) % 16)
          rob_q.push_back(id);
        m_tail = int'(flush_robid);
        m_pc   = int'(flush_pc);
      end else if (fire) begin
        exp_q.push_back('{instr: 'h1000 + m_pc, pc: m_pc, rid: m_tail});
        rob_q.push_back(m_tail);
        m_tail = (m_tail + 1) % 16;
        m_pc   = (m_pc + 1) % 64;
      end
    end
  end

  // Monitor: compares the DUT state presented before each active edge.
  always @(negedge clk) begin
    chk("imem_addr", imem_addr, m_pc);
    chk("rob_count", rob_count, rob_q.size());
    chk("rob_full", rob_full, rob_q.size() == 16);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      if (out_valid) begin
        chk("out_instr", out_instr, exp_q[0].instr);
        chk("out_pc", out_pc, exp_q[0].pc);
        chk("out_robid", out_robid, exp_q[0].rid);
      end
      if (out_ready && !flush_valid && !rst)
        void'(exp_q.pop_front());
    end
  end

  task automatic step(input logic rdy, input logic ret, input logic fl,
                      input int fpc, input int frid, input int n);
    out_ready    = rdy;
    retire_valid = ret;
    flush_valid  = fl;
    flush_pc     = 6'(fpc);
    flush_robid  = 4'(frid);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst          = 1'b1;
    out_ready    = 1'b0;
    retire_valid = 1'b0;
    flush_valid  = 1'b0;
    flush_pc     = '0;
    flush_robid  = '0;
    #23 rst = 1'b0;

    step(1, 0, 0, 0, 0, 3);                    // pc 0,1,2 back to back
    step(0, 0, 0, 0, 0, 3);                    // hold at pc 2
    step(1, 0, 0, 0, 0, 16);                   // fill the ROB
    step(1, 1, 0, 0, 0, 1);                    // one retire frees one slot
    step(1, 0, 0, 0, 0, 3);
    step(1, 0, 1, 'h20, (m_head + 3) % 16, 1); // redirect with rollback
    step(1, 0, 0, 0, 0, 2);
    step(0, 1, 1, 'h10, m_head, 1);            // retire applied before rollback
    step(1, 0, 0, 0, 0, 2);
    step(0, 0, 1, 0, m_head, 1);               // empty the ROB
    step(0, 1, 0, 0, 0, 2);                    // retire on empty ROB
    step(1, 0, 1, 'h3E, m_head, 1);
    step(1, 1, 0, 0, 0, 4);                    // pc wraps 3F -> 0

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 31) == 0, $urandom_range(0, 63),
           $urandom_range(0, 15), 1);
    end

    // asynchronous reset in the middle of traffic
    step(1, 0, 0, 0, 0, 2);
    #2 rst = 1'b1;
    #9 rst = 1'b0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 5);
    step(0, 0, 0, 0, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
